// File: rtl/wide_add_sequencer.sv
// Multi-cycle WORDS*N-bit adder that reuses one N-bit ripple-carry adder per chunk, LSB chunk first.
// Optional macro SUB_EN adds an in_sub port that turns the operation into A-B.

module RippleCarryAdder #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[N];

endmodule

module wide_add_sequencer #(
   parameter int N     = 16,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WORDS-1:0] in_a,
   input  logic [N*WORDS-1:0] in_b,
   input  logic               in_cin,
`ifdef SUB_EN
   input  logic               in_sub,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WORDS-1:0] out_sum,
   output logic               out_cout,
   output logic               busy
);

   localparam int W  = N * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic          cin_reg;
   logic          carry;
   logic [KW-1:0] k;
   logic [N-1:0]  add_a;
   logic [N-1:0]  add_b;
   logic [N-1:0]  add_s;
   logic          add_cin;
   logic          add_cout;
   logic          last;
`ifdef SUB_EN
   logic          sub_reg;
`endif

   assign last  = (k == KLAST);
   assign add_a = a_reg[k*N +: N];
`ifdef SUB_EN
   assign add_b = b_reg[k*N +: N] ^ {N{sub_reg}};
`else
   assign add_b = b_reg[k*N +: N];
`endif
   // cin_reg already holds the forced 1 for subtraction, so chunk 0 needs no mode check
   assign add_cin = (k == '0) ? cin_reg : carry;

   RippleCarryAdder #(.N(N)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_s),
      .cout (add_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // in_ready is held low while rst is asserted so nothing looks acceptable during reset
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         cin_reg  <= 1'b0;
         carry    <= 1'b0;
         k        <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
`ifdef SUB_EN
         sub_reg  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg   <= in_a;
                  b_reg   <= in_b;
                  carry   <= 1'b0;
                  k       <= '0;
`ifdef SUB_EN
                  sub_reg <= in_sub;
                  cin_reg <= in_sub ? 1'b1 : in_cin;
`else
                  cin_reg <= in_cin;
`endif
               end
            end
            RUN: begin
               out_sum[k*N +: N] <= add_s;
               carry             <= add_cout;
               if (last) begin
                  out_cout <= add_cout;
                  k        <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (N=16, WORDS=4): directed table, hold, reset, back-to-back and random ops.
// Subtract vectors are included only when SUB_EN is defined.

module tb_wide_add_sequencer;

   localparam int N     = 16;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a      = '0;
   logic [W-1:0] in_b      = '0;
   logic         in_cin    = 1'b0;
   logic         in_sub    = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] expSum;
      logic         expCout;
      int           hold;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   // Reference: the whole-width arithmetic result, {cout, sum}
   function automatic logic [W:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
      if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full operation: accept, scramble inputs, measure latency, optional DONE hold, release
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, input logic [W-1:0] expSum, input logic expCout,
                                input int hold, input string tag);
      int cnt;
      logic [W-1:0] held;
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput({tag, "_ready"}, 128'(in_ready), 128'(1));
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = {$urandom, $urandom};
      in_b     = {$urandom, $urandom};
      in_cin   = 1'($urandom);
      in_sub   = 1'($urandom);
      checkOutput({tag, "_busy"}, 128'({busy, in_ready, out_valid}), 128'(3'b100));
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput({tag, "_latency"}, 128'(cnt), 128'(WORDS));
      checkOutput({tag, "_result"}, 128'({out_cout, out_sum}), 128'({expCout, expSum}));
      held = out_sum;
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         in_a     = {$urandom, $urandom};
         @(negedge clk);
         checkOutput({tag, "_hold"}, 128'({in_ready, out_valid, out_sum}), 128'({1'b0, 1'b1, held}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, "_release"}, 128'({in_ready, out_valid, busy}), 128'(3'b100));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [W:0]   expQ[$];
      logic [W:0]   r;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      int           results;
      int           pushes;
      int           lastCycle;

      vecs.push_back(vec_t'{{W{1'b1}}, '0, 1'b1, 1'b0, '0, 1'b1, 0});
      vecs.push_back(vec_t'{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                            64'h1234_5678_9ABC_DF00, 1'b0, 10});
      vecs.push_back(vec_t'{'0, '0, 1'b0, 1'b0, '0, 1'b0, 0});
      vecs.push_back(vec_t'{{W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, {W{1'b1}}, 1'b1, 1});
      vecs.push_back(vec_t'{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 0});
      vecs.push_back(vec_t'{64'h0000_FFFF_FFFF_FFFF, '0, 1'b1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 2});
      vecs.push_back(vec_t'{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, '0, 1'b1, 0});
`ifdef SUB_EN
      vecs.push_back(vec_t'{'0, 64'h1, 1'b0, 1'b1, {W{1'b1}}, 1'b0, 0});
      vecs.push_back(vec_t'{64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 0});
      vecs.push_back(vec_t'{64'h5, 64'h3, 1'b1, 1'b1, 64'h2, 1'b1, 1});
`endif

      #1;
      checkOutput("reset_outputs", 128'({out_valid, busy, out_cout, out_sum}), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset_release", 128'({in_ready, out_valid, busy}), 128'(3'b100));
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                       vecs[i].expSum, vecs[i].expCout, vecs[i].hold, $sformatf("vec%0d", i));

      // Abort an operation once chunks 0 and 1 are written (k==2)
      in_a = 64'h0000_0000_8000_FFFF; in_b = 64'h1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_partial", 128'({busy, out_valid, out_sum[2*N-1:0]}), 128'({1'b1, 1'b0, 32'h8001_0000}));
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_immediate", 128'({out_valid, busy, out_cout, out_sum}), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_after", 128'({in_ready, out_valid, busy, out_sum}), 128'({3'b100, {W{1'b0}}}));
      @(negedge clk);
      applyStimulus(vecs[1].a, vecs[1].b, vecs[1].cin, vecs[1].sub,
                    vecs[1].expSum, vecs[1].expCout, 0, "post_rst");

      // Back-to-back with in_valid and out_ready held high
      results = 0; pushes = 0; lastCycle = -1;
      out_ready = 1'b1;
      for (int cycle = 0; cycle < 100 && results < 5; cycle++) begin
         if (out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("b2b_extra", 128'(1), 128'(0));
            end else begin
               r = expQ.pop_front();
               checkOutput("b2b_result", 128'({out_cout, out_sum}), 128'(r));
            end
            if (lastCycle >= 0) checkOutput("b2b_interval", 128'(cycle - lastCycle), 128'(WORDS + 2));
            lastCycle = cycle;
            results++;
         end
         if (in_ready && pushes < 5) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
            in_a = ra; in_b = rb; in_cin = rc; in_sub = 1'b0; in_valid = 1'b1;
            expQ.push_back(refModel(ra, rb, rc, 1'b0));
            pushes++;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("b2b_count", 128'(results), 128'(5));
      checkOutput("b2b_drain", 128'(expQ.size()), 128'(0));
      @(negedge clk);

      // Random operations, every fourth one forcing a full-width carry chain
      for (int i = 0; i < 25; i++) begin
         ra = {$urandom, $urandom};
         rb = (i % 4 == 0) ? ~ra : {$urandom, $urandom};
         rc = (i % 4 == 0) ? 1'b1 : 1'($urandom);
`ifdef SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         r = refModel(ra, rb, rc, rs);
         applyStimulus(ra, rb, rc, rs, r[W-1:0], r[W], $urandom_range(0, 2), $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
